// File: rtl/ym_wrbuf_if.sv
// ym_wrbuf_if
//   Bus-controller side of the YM2203 write-posting buffer.
//   wr_stb  : one-cycle strobe, posts {wr_chip, wr_a0, wr_data}
//   wr_chip : 0 = YM #0, 1 = YM #1
//   wr_a0   : 0 = address write, 1 = data write
//   wr_data : byte to write
//   rd_req  : bus controller wants the YM pins for a read
//   rd_gnt  : pins released, the read may proceed
//   full    : write FIFO full
//   empty   : write FIFO empty and sequencer idle
//   master modport = bus controller, slave modport = ym_wrbuf.
interface ym_wrbuf_if;
  logic       wr_stb;
  logic       wr_chip;
  logic       wr_a0;
  logic [7:0] wr_data;
  logic       rd_req;
  logic       rd_gnt;
  logic       full;
  logic       empty;

  modport master (
    output wr_stb, wr_chip, wr_a0, wr_data, rd_req,
    input  rd_gnt, full, empty
  );

  modport slave (
    input  wr_stb, wr_chip, wr_a0, wr_data, rd_req,
    output rd_gnt, full, empty
  );
endinterface

// File: rtl/ym_wrbuf.sv
// ym_wrbuf
//   Write-posting buffer between the bus controller and two YM2203 chips.
//   Posted writes go into a FIFO and are replayed with CS/WR setup, strobe
//   and hold timing, followed by a per-chip busy recovery that depends on
//   the kind of write and on the chip's last selected register.
//   Reads are not buffered: the bus controller asks for the pins with
//   rd_req and waits for rd_gnt.
//
// Ports
//   clk, rst_n      : fclk, asynchronous active-low reset
//   bus (slave)     : wr_stb/wr_chip/wr_a0/wr_data, rd_req/rd_gnt, full/empty
//   ymcs0_n/ymcs1_n : chip selects
//   ymwr_n, yma0    : write strobe and A0
//   d_out, d_oe     : local data bus value and its drive enable
//
// Build option
//   YM_WRBUF_OVF_EN : adds ovf_clr (in), ovf (out, sticky overflow flag)
//                     and level (out, FIFO occupancy).
module ym_wrbuf #(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned T_SU     = 3,
  parameter int unsigned T_WR     = 8,
  parameter int unsigned T_HD     = 2,
  parameter int unsigned REC_ADDR = 272,
  parameter int unsigned REC_FM1  = 1328,
  parameter int unsigned REC_FM2  = 752,
  parameter int unsigned REC_SSG  = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  ym_wrbuf_if.slave              bus,
  output logic                   ymcs0_n,
  output logic                   ymcs1_n,
  output logic                   ymwr_n,
  output logic                   yma0,
  output logic [7:0]             d_out,
  output logic                   d_oe
`ifdef YM_WRBUF_OVF_EN
  ,
  input  logic                   ovf_clr,
  output logic                   ovf,
  output logic [$clog2(DEPTH):0] level
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned TW = 8;
  localparam int unsigned RW = 11;

  typedef struct packed {
    logic       chip;
    logic       a0;
    logic [7:0] data;
  } entry_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_GRANT
  } state_e;

  // FIFO
  entry_t        mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] count;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  entry_t        head;

  // Sequencer
  state_e        state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          done;
  logic          active;
  entry_t        cur_q, cur_d;

  // Per-chip shadows and recovery counters
  logic [7:0]    shadow_q [2];
  logic [7:0]    shadow_d [2];
  logic [RW-1:0] rec_q [2];
  logic [RW-1:0] rec_d [2];
  logic [RW-1:0] rec_val;
  logic          head_ready;

  // ---------------------------------------------------------------- FIFO
  assign count      = wr_ptr_q - rd_ptr_q;
  assign fifo_full  = (count == PW'(DEPTH));
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign push       = bus.wr_stb && !fifo_full;
  assign head       = mem_q[rd_ptr_q[AW-1:0]];
  assign wr_ptr_d   = wr_ptr_q + PW'(push);
  assign rd_ptr_d   = rd_ptr_q + PW'(pop);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {bus.wr_chip, bus.wr_a0, bus.wr_data};
    end
  end

  // A head entry may only issue once its own chip has recovered; the other
  // chip's counter is irrelevant.
  assign head_ready = (rec_q[head.chip] == '0);

  // ---------------------------------------------- sequencer: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
    end
  end

  // ---------------------------------------------- sequencer: next state
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    pop     = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.rd_req) begin
          state_d = S_GRANT;
        end else if (!fifo_empty && head_ready) begin
          pop     = 1'b1;
          state_d = S_SETUP;
          tmr_d   = TW'(T_SU - 1);
        end
      end
      S_SETUP: begin
        if (tmr_q == '0) begin
          state_d = S_STROBE;
          tmr_d   = TW'(T_WR - 1);
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      S_STROBE: begin
        if (tmr_q == '0) begin
          state_d = S_HOLD;
          tmr_d   = TW'(T_HD - 1);
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      S_HOLD: begin
        if (tmr_q == '0) begin
          state_d = S_IDLE;
          done    = 1'b1;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      S_GRANT: begin
        if (!bus.rd_req) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------- sequencer: outputs
  always_comb begin
    active      = (state_q == S_SETUP) || (state_q == S_STROBE) ||
                  (state_q == S_HOLD);
    ymcs0_n     = !(active && !cur_q.chip);
    ymcs1_n     = !(active && cur_q.chip);
    ymwr_n      = (state_q != S_STROBE);
    yma0        = active && cur_q.a0;
    d_out       = active ? cur_q.data : '0;
    d_oe        = active;
    bus.rd_gnt  = (state_q == S_GRANT) && bus.rd_req;
    bus.full    = fifo_full;
    bus.empty   = fifo_empty && ((state_q == S_IDLE) || (state_q == S_GRANT));
  end

  // ---------------------------------------------- shadows and recovery
  assign cur_d = pop ? head : cur_q;

  always_comb begin
    shadow_d = shadow_q;
    if (pop && !head.a0) begin
      shadow_d[head.chip] = head.data;
    end
  end

  // The shadow of the finishing chip already holds the register selected by
  // its last address write, so the recovery class is known at HOLD exit.
  always_comb begin
    if (!cur_q.a0) begin
      rec_val = RW'(REC_ADDR);
    end else if (shadow_q[cur_q.chip] inside {[8'h21:8'h9F]}) begin
      rec_val = RW'(REC_FM1);
    end else if (shadow_q[cur_q.chip] inside {[8'hA0:8'hB6]}) begin
      rec_val = RW'(REC_FM2);
    end else begin
      rec_val = RW'(REC_SSG);
    end
  end

  always_comb begin
    for (int unsigned ch = 0; ch < 2; ch++) begin
      rec_d[ch] = rec_q[ch];
      if (done && (cur_q.chip == 1'(ch))) begin
        rec_d[ch] = rec_val;
      end else if (rec_q[ch] != '0) begin
        rec_d[ch] = rec_q[ch] - RW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cur_q    <= '0;
      for (int unsigned ch = 0; ch < 2; ch++) begin
        shadow_q[ch] <= '0;
        rec_q[ch]    <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cur_q    <= cur_d;
      for (int unsigned ch = 0; ch < 2; ch++) begin
        shadow_q[ch] <= shadow_d[ch];
        rec_q[ch]    <= rec_d[ch];
      end
    end
  end

`ifdef YM_WRBUF_OVF_EN
  // ---------------------------------------------- overflow flag and level
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (bus.wr_stb && fifo_full) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf   = ovf_q;
  assign level = count;
`endif

endmodule

// File: tb/tb_ym_wrbuf.sv
`timescale 1ns/1ps
module tb_ym_wrbuf;
  localparam int REC_ADDR = 272;
  localparam int REC_FM1  = 1328;
  localparam int REC_FM2  = 752;
  localparam int REC_SSG  = 0;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ym_wrbuf_if bus();
  logic       ymcs0_n, ymcs1_n, ymwr_n, yma0, d_oe;
  logic [7:0] d_out;
`ifdef YM_WRBUF_OVF_EN
  logic       ovf_clr = 1'b0;
  logic       ovf;
  logic [4:0] level;
`endif

  ym_wrbuf #(
    .DEPTH(16), .T_SU(3), .T_WR(8), .T_HD(2),
    .REC_ADDR(REC_ADDR), .REC_FM1(REC_FM1), .REC_FM2(REC_FM2), .REC_SSG(REC_SSG)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .ymcs0_n(ymcs0_n), .ymcs1_n(ymcs1_n), .ymwr_n(ymwr_n), .yma0(yma0),
    .d_out(d_out), .d_oe(d_oe)
`ifdef YM_WRBUF_OVF_EN
    , .ovf_clr(ovf_clr), .ovf(ovf), .level(level)
`endif
  );

  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input longint obs, input longint expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic chk_rng(input string tag, input longint obs, input longint lo, input longint hi);
    vectors++;
    assert (((obs >= lo) && (obs <= hi)) === 1'b1) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // ------------------------------------------------------ reference model
  typedef struct packed { bit chip; bit a0; bit [7:0] d; } wr_t;
  wr_t  exp_q[$];
  bit [7:0] shadow [2];
  int   req [2];
  int   rise_cyc [2];
  bit   have_rise [2];
  int   n_wr [2];
  int   gaps0[$];
  int   gaps1[$];
  bit   was_low [2];
  bit   seen_wr [2];
  bit   lo [2];
  int   low_n [2];
  int   wr_n [2];
  int   su_n [2];
  wr_t  cur [2];

  // Busy time a YM2203 needs after a write, in fclk cycles.
  function automatic int rec_for(input wr_t w, input bit [7:0] sh);
    if (!w.a0) return REC_ADDR;
    if (sh >= 8'h21 && sh <= 8'h9F) return REC_FM1;
    if (sh >= 8'hA0 && sh <= 8'hB6) return REC_FM2;
    return REC_SSG;
  endfunction

  // Pin monitor: every write seen on the pins must be the next expected one,
  // with 3/8/2 timing and at least the chip's required recovery before it.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int ch = 0; ch < 2; ch++) begin
        was_low[ch] = 0; have_rise[ch] = 0; shadow[ch] = 0; req[ch] = 0;
      end
      exp_q.delete();
    end else begin
      lo[0] = !ymcs0_n;
      lo[1] = !ymcs1_n;
      chk("cs overlap", lo[0] && lo[1], 0);
      chk("gnt while cs", bus.rd_gnt && (lo[0] || lo[1]), 0);
      if (!lo[0] && !lo[1]) begin
        chk("idle wr/oe/a0", {ymwr_n, d_oe, yma0}, 3'b100);
        chk("idle d_out", d_out, 0);
      end
      for (int ch = 0; ch < 2; ch++) begin
        if (lo[ch] && !was_low[ch]) begin
          chk("write expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            cur[ch] = exp_q.pop_front();
            chk("write chip", ch, cur[ch].chip);
            chk("write a0", yma0, cur[ch].a0);
            chk("write data", d_out, cur[ch].d);
          end
          if (have_rise[ch]) begin
            int gap;
            gap = cyc - rise_cyc[ch];
            chk($sformatf("chip%0d recovery gap %0d >= %0d", ch, gap, req[ch]), gap >= req[ch], 1);
            if (ch == 0) gaps0.push_back(gap); else gaps1.push_back(gap);
          end
          low_n[ch] = 0; wr_n[ch] = 0; su_n[ch] = 0; seen_wr[ch] = 0;
        end
        if (lo[ch]) begin
          low_n[ch]++;
          if (!ymwr_n) begin
            wr_n[ch]++;
            seen_wr[ch] = 1;
          end else if (!seen_wr[ch]) begin
            su_n[ch]++;
          end
          chk("d_oe during cs", d_oe, 1);
        end
        if (!lo[ch] && was_low[ch]) begin
          chk("cs low cycles", low_n[ch], 13);
          chk("wr low cycles", wr_n[ch], 8);
          chk("setup cycles", su_n[ch], 3);
          if (!cur[ch].a0) shadow[ch] = cur[ch].d;
          req[ch] = rec_for(cur[ch], shadow[ch]);
          rise_cyc[ch] = cyc;
          have_rise[ch] = 1;
          n_wr[ch]++;
        end
        was_low[ch] = lo[ch];
      end
    end
  end

  // ------------------------------------------------------ stimulus helpers
  // Called one time unit after a rising edge; returns likewise.
  task automatic push(input bit chip, input bit a0, input bit [7:0] d, input bit accept);
    wr_t e;
    bus.wr_stb  = 1'b1;
    bus.wr_chip = chip;
    bus.wr_a0   = a0;
    bus.wr_data = d;
    if (accept) begin
      e.chip = chip; e.a0 = a0; e.d = d;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    bus.wr_stb = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int maxc);
    int n = 0;
    while (!(bus.empty && exp_q.size() == 0 && ymcs0_n && ymcs1_n) && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk_rng({tag, " drain cycles"}, n, 0, maxc - 1);
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_pins(input string tag);
    chk({tag, " ymcs0_n"}, ymcs0_n, 1);
    chk({tag, " ymcs1_n"}, ymcs1_n, 1);
    chk({tag, " ymwr_n"}, ymwr_n, 1);
    chk({tag, " yma0"}, yma0, 0);
    chk({tag, " d_out"}, d_out, 0);
    chk({tag, " d_oe"}, d_oe, 0);
    chk({tag, " rd_gnt"}, bus.rd_gnt, 0);
    chk({tag, " full"}, bus.full, 0);
    chk({tag, " empty"}, bus.empty, 1);
`ifdef YM_WRBUF_OVF_EN
    chk({tag, " ovf"}, ovf, 0);
    chk({tag, " level"}, level, 0);
`endif
  endtask

  initial begin
    #900us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ------------------------------------------------------ directed sequence
  bit [7:0] atab [6] = '{8'h07, 8'h28, 8'hA4, 8'hB0, 8'h10, 8'h50};

  initial begin
    int n, base0;
    bit c, a;
    bit [7:0] d;

    bus.wr_stb = 0; bus.wr_chip = 0; bus.wr_a0 = 0; bus.wr_data = 0; bus.rd_req = 0;
    rst_n = 0;
    #12;
    chk_reset_pins("reset");
    @(posedge clk); #1 rst_n = 1;
    @(posedge clk); #1;

    // Single address write: 2-cycle latency, then 272 / 1328 recovery
    push(0, 0, 8'h28, 1);
    n = 1;
    @(negedge clk);
    while (ymcs0_n && n < 10) begin @(negedge clk); n++; end
    chk("first write latency", n, 2);
    @(posedge clk); #1;
    push(0, 1, 8'hF0, 1);
    push(0, 1, 8'($urandom), 1);
    wait_drain("fm1", 4000);
    chk("fm1 gap count", gaps0.size(), 2);
    if (gaps0.size() == 2) begin
      chk_rng("addr recovery", gaps0[0], REC_ADDR, REC_ADDR + 3);
      chk_rng("fm1 recovery", gaps0[1], REC_FM1, REC_FM1 + 3);
    end

    // 0xA4 -> FM2 class
    gaps0.delete();
    push(0, 0, 8'hA4, 1);
    push(0, 1, 8'($urandom), 1);
    push(0, 1, 8'($urandom), 1);
    wait_drain("fm2", 5000);
    chk("fm2 gap count", gaps0.size(), 3);
    if (gaps0.size() == 3) chk_rng("fm2 recovery", gaps0[2], REC_FM2, REC_FM2 + 3);

    // 0x07 -> SSG, no wait
    gaps0.delete();
    push(0, 0, 8'h07, 1);
    push(0, 1, 8'($urandom), 1);
    push(0, 1, 8'($urandom), 1);
    wait_drain("ssg", 3000);
    chk("ssg gap count", gaps0.size(), 3);
    if (gaps0.size() == 3) chk_rng("ssg recovery", gaps0[2], 1, 2);

    // Interleaved chips: chip 1 issues during chip 0 FM1 recovery
    base0 = n_wr[0];
    push(0, 0, 8'h28, 1);
    push(0, 1, 8'($urandom), 1);
    push(1, 0, 8'h07, 1);
    push(1, 1, 8'($urandom), 1);
    push(1, 1, 8'($urandom), 1);
    push(0, 1, 8'($urandom), 1);
    n = 0;
    while (n_wr[0] < base0 + 2 && n < 2000) begin @(negedge clk); n++; end
    chk_rng("chip0 data done", n, 0, 1999);
    n = 0;
    while (ymcs1_n && n < 2000) begin @(negedge clk); n++; end
    chk_rng("chip1 during chip0 recovery", cyc - rise_cyc[0], 0, REC_FM1 - 1);
    @(posedge clk); #1;
    wait_drain("interleave", 4000);

    // Randomized traffic, never more than 12 outstanding
    for (int i = 0; i < 24; i++) begin
      n = 0;
      while (exp_q.size() >= 12 && n < 5000) begin @(negedge clk); n++; end
      chk_rng("rand backlog wait", n, 0, 4999);
      @(posedge clk); #1;
      c = 1'($urandom);
      a = 1'($urandom);
      d = a ? 8'($urandom) : atab[$urandom_range(0, 5)];
      push(c, a, d, 1);
      repeat ($urandom_range(0, 40)) @(posedge clk);
      #1;
    end
    wait_drain("random", 40000);

    // Overflow while chip 0 recovers from an FM1 data write
    push(0, 0, 8'h28, 1);
    push(0, 1, 8'($urandom), 1);
    wait_drain("ovf prep", 3000);
    push(0, 0, 8'h07, 1);
    for (int i = 0; i < 15; i++) push(0, 1, 8'($urandom), 1);
    chk("full at 16", bus.full, 1);
    chk("not empty at 16", bus.empty, 0);
`ifdef YM_WRBUF_OVF_EN
    chk("ovf before drop", ovf, 0);
    chk("level at 16", level, 16);
`endif
    push(0, 1, 8'h5A, 0);
    chk("full after drop", bus.full, 1);
`ifdef YM_WRBUF_OVF_EN
    chk("ovf after drop", ovf, 1);
    chk("level after drop", level, 16);
    ovf_clr = 1;
    @(posedge clk); #1 ovf_clr = 0;
    chk("ovf cleared", ovf, 0);
`endif
    wait_drain("ovf", 6000);
    chk("full after drain", bus.full, 0);

    // Read request during STROBE
    gaps0.delete();
    push(0, 0, 8'h07, 1);
    n = 0;
    while (ymwr_n && n < 30) begin @(negedge clk); n++; end
    chk_rng("strobe reached", n, 0, 29);
    @(posedge clk); #1;
    push(1, 1, 8'($urandom), 1);
    bus.rd_req = 1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      chk("rd_gnt held during write", bus.rd_gnt, 0);
    end while (!ymcs0_n && n < 30);
    @(negedge clk);
    chk("rd_gnt after hold", bus.rd_gnt, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("grant: no cs", {ymcs0_n, ymcs1_n}, 2'b11);
      chk("grant: rd_gnt", bus.rd_gnt, 1);
    end
    @(posedge clk); #1 bus.rd_req = 0;
    #1 chk("rd_gnt drop", bus.rd_gnt, 0);
    @(posedge clk); #1;
    push(0, 1, 8'($urandom), 1);
    wait_drain("read", 2000);
    chk("read gap count", gaps0.size(), 2);
    if (gaps0.size() == 2) chk_rng("recovery counts during grant", gaps0[1], REC_ADDR, REC_ADDR + 3);

    // Reset during STROBE
    push(0, 0, 8'hA4, 1);
    n = 0;
    while (ymwr_n && n < 30) begin @(negedge clk); n++; end
    chk_rng("strobe before reset", n, 0, 29);
    #2 rst_n = 0;
    #1 chk_reset_pins("mid-write reset");
    @(negedge clk);
    @(posedge clk); #1 rst_n = 1;
    gaps0.delete();
    @(posedge clk); #1;
    push(0, 1, 8'($urandom), 1);
    push(0, 1, 8'($urandom), 1);
    wait_drain("post reset", 2000);
    chk("post reset gap count", gaps0.size(), 1);
    if (gaps0.size() == 1) chk_rng("shadow cleared by reset", gaps0[0], 1, 2);

    chk("final queue empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
